// File: rtl/rename_regfile_pkg.sv
// Shared defaults and helpers for the rename register file.
// The busy+tag entry type describes one rename-table slot at default widths.
package rename_regfile_pkg;

    localparam int NUM_REGS_D = 32;
    localparam int REG_W_D    = 5;
    localparam int XLEN_D     = 32;
    localparam int ROB_W_D    = 4;
    localparam int NUM_RD_D   = 2;
    localparam int NUM_CMT_D  = 2;

    typedef struct packed {
        logic               busy;
        logic [ROB_W_D-1:0] tag;
    } rt_entry_t;

    localparam int RT_ENTRY_W = $bits(rt_entry_t);

    // Width of a port-select field; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rename_regfile_cmt_match.sv
// rf_cmt_match: priority match of one register index against all commit ports.
// The youngest (highest-index) matching port wins. With tag_en set the
// commit tag must also equal tag_ref; with it clear any destination match counts.
module rf_cmt_match
    import rename_regfile_pkg::*;
#(
    parameter int REG_W   = REG_W_D,
    parameter int XLEN    = XLEN_D,
    parameter int ROB_W   = ROB_W_D,
    parameter int NUM_CMT = NUM_CMT_D,
    parameter int SEL_W   = sel_width(NUM_CMT_D)
) (
    input  logic [REG_W-1:0]         idx,
    input  logic                     tag_en,
    input  logic [ROB_W-1:0]         tag_ref,
    input  logic [NUM_CMT-1:0]       cmt_vld,
    input  logic [NUM_CMT*REG_W-1:0] cmt_rd,
    input  logic [NUM_CMT*XLEN-1:0]  cmt_val,
    input  logic [NUM_CMT*ROB_W-1:0] cmt_tag,
    output logic                     hit,
    output logic [XLEN-1:0]          val,
    output logic [SEL_W-1:0]         sel
);

    // Scan ports oldest to youngest so the last match (youngest) sticks.
    always_comb begin
        hit = 1'b0;
        val = '0;
        sel = '0;
        for (int k = 0; k < NUM_CMT; k++) begin
            if (cmt_vld[k] && (idx != '0) && (cmt_rd[k*REG_W +: REG_W] == idx) &&
                (!tag_en || (cmt_tag[k*ROB_W +: ROB_W] == tag_ref))) begin
                hit = 1'b1;
                val = cmt_val[k*XLEN +: XLEN];
                sel = SEL_W'(k);
            end else begin
                hit = hit;
            end
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file with per-register rename tags.
// Combinational reads with commit bypass, one rename and NUM_CMT commits per
// cycle, rollback clears every busy bit. x0 is hardwired to zero.
// Optional macro REGFILE_CHECKPOINT_EN adds a one-deep busy/tag snapshot
// (ckpt_save / ckpt_restore ports); restore takes the place of rollback's clear.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_D,
    parameter int REG_W    = REG_W_D,
    parameter int XLEN     = XLEN_D,
    parameter int ROB_W    = ROB_W_D,
    parameter int NUM_RD   = NUM_RD_D,
    parameter int NUM_CMT  = NUM_CMT_D
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic [NUM_RD*REG_W-1:0]       rd_idx,
    output logic [NUM_RD*XLEN-1:0]        rd_val,
    output logic [NUM_RD-1:0]             rd_busy,
    output logic [NUM_RD*ROB_W-1:0]       rd_tag,
    input  logic                          issue,
    input  logic [REG_W-1:0]              issue_rd,
    input  logic [ROB_W-1:0]              issue_tag,
    input  logic [NUM_CMT-1:0]            cmt_vld,
    input  logic [NUM_CMT*REG_W-1:0]      cmt_rd,
    input  logic [NUM_CMT*XLEN-1:0]       cmt_val,
    input  logic [NUM_CMT*ROB_W-1:0]      cmt_tag,
    input  logic                          rollback,
`ifdef REGFILE_CHECKPOINT_EN
    input  logic                          ckpt_save,
    input  logic                          ckpt_restore,
`endif
    output logic [$clog2(NUM_REGS+1)-1:0] busy_cnt
);

    localparam int SEL_W = sel_width(NUM_CMT);
    localparam int CNT_W = $clog2(NUM_REGS+1);

    logic [XLEN-1:0]     val_r [NUM_REGS];
    logic [NUM_REGS-1:0] busy_r;
    logic [ROB_W-1:0]    tag_r [NUM_REGS];
    logic [CNT_W-1:0]    busy_cnt_r;

    logic [XLEN-1:0]     val_s [NUM_REGS];
    logic [NUM_REGS-1:0] busy_s;
    logic [ROB_W-1:0]    tag_s [NUM_REGS];
    logic [CNT_W-1:0]    cnt_s;

    logic [NUM_REGS-1:0] wr_hit_s;
    logic [XLEN-1:0]     wr_val_s [NUM_REGS];
    logic [SEL_W-1:0]    wr_sel_s [NUM_REGS];

`ifdef REGFILE_CHECKPOINT_EN
    logic [NUM_REGS-1:0] snap_busy_r;
    logic [ROB_W-1:0]    snap_tag_r [NUM_REGS];
    logic [NUM_REGS-1:0] snap_busy_s;
    logic [ROB_W-1:0]    snap_tag_s [NUM_REGS];
    logic                snap_kill_s;
`endif

    assign busy_cnt = busy_cnt_r;

    // Read ports: x0, then youngest tag-matching commit bypass, then stored entry.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [REG_W-1:0] idx_s;
        logic             byp_hit_s;
        logic [XLEN-1:0]  byp_val_s;
        logic [SEL_W-1:0] byp_sel_s;
        logic [XLEN-1:0]  pval_s;
        logic             pbusy_s;
        logic [ROB_W-1:0] ptag_s;

        assign idx_s = rd_idx[p*REG_W +: REG_W];

        rf_cmt_match #(
            .REG_W(REG_W), .XLEN(XLEN), .ROB_W(ROB_W), .NUM_CMT(NUM_CMT), .SEL_W(SEL_W)
        ) u_byp (
            .idx(idx_s), .tag_en(1'b1), .tag_ref(tag_r[idx_s]),
            .cmt_vld(cmt_vld), .cmt_rd(cmt_rd), .cmt_val(cmt_val), .cmt_tag(cmt_tag),
            .hit(byp_hit_s), .val(byp_val_s), .sel(byp_sel_s)
        );

        // Resolve one read port from stored state and in-flight commits.
        always_comb begin
            if (idx_s == '0) begin
                pval_s  = '0;
                pbusy_s = 1'b0;
                ptag_s  = '0;
            end else if (byp_hit_s && busy_r[idx_s]) begin
                pval_s  = byp_val_s;
                pbusy_s = 1'b0;
                ptag_s  = cmt_tag[byp_sel_s*ROB_W +: ROB_W];
            end else begin
                pval_s  = val_r[idx_s];
                pbusy_s = busy_r[idx_s];
                ptag_s  = tag_r[idx_s];
            end
        end

        assign rd_val[p*XLEN +: XLEN]   = pval_s;
        assign rd_busy[p]               = pbusy_s;
        assign rd_tag[p*ROB_W +: ROB_W] = ptag_s;
    end

    // Per-register youngest commit, independent of tag, drives write and busy clear.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_wr
        rf_cmt_match #(
            .REG_W(REG_W), .XLEN(XLEN), .ROB_W(ROB_W), .NUM_CMT(NUM_CMT), .SEL_W(SEL_W)
        ) u_wr (
            .idx(REG_W'(i)), .tag_en(1'b0), .tag_ref(tag_r[i]),
            .cmt_vld(cmt_vld), .cmt_rd(cmt_rd), .cmt_val(cmt_val), .cmt_tag(cmt_tag),
            .hit(wr_hit_s[i]), .val(wr_val_s[i]), .sel(wr_sel_s[i])
        );
    end

    // Next state: commits, then issue, then rollback/restore; x0 pinned to zero.
    always_comb begin
        cnt_s = '0;
`ifdef REGFILE_CHECKPOINT_EN
        snap_kill_s = 1'b0;
`endif
        for (int i = 0; i < NUM_REGS; i++) begin
            val_s[i]  = val_r[i];
            busy_s[i] = busy_r[i];
            tag_s[i]  = tag_r[i];
            if (wr_hit_s[i]) begin
                val_s[i]  = wr_val_s[i];
                busy_s[i] = busy_r[i] & (cmt_tag[wr_sel_s[i]*ROB_W +: ROB_W] != tag_r[i]);
            end else begin
                val_s[i]  = val_r[i];
            end
            if (issue && (issue_rd != '0) && (issue_rd == REG_W'(i))) begin
                busy_s[i] = 1'b1;
                tag_s[i]  = issue_tag;
            end else begin
                tag_s[i]  = tag_s[i];
            end
`ifdef REGFILE_CHECKPOINT_EN
            snap_busy_s[i] = (ckpt_save && !ckpt_restore) ? busy_s[i] : snap_busy_r[i];
            snap_tag_s[i]  = (ckpt_save && !ckpt_restore) ? tag_s[i]  : snap_tag_r[i];
            snap_kill_s = 1'b0;
            for (int k = 0; k < NUM_CMT; k++) begin
                snap_kill_s = snap_kill_s |
                    (cmt_vld[k] && (cmt_tag[k*ROB_W +: ROB_W] == snap_tag_r[i]));
            end
            if (ckpt_restore) begin
                busy_s[i] = snap_busy_r[i] & ~snap_kill_s;
                tag_s[i]  = snap_tag_r[i];
            end else if (rollback) begin
                busy_s[i] = 1'b0;
            end else begin
                busy_s[i] = busy_s[i];
            end
`else
            if (rollback) begin
                busy_s[i] = 1'b0;
            end else begin
                busy_s[i] = busy_s[i];
            end
`endif
        end
        val_s[0]  = '0;
        busy_s[0] = 1'b0;
        tag_s[0]  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_s = cnt_s + CNT_W'(busy_s[i]);
        end
    end

    // State registers: synchronous active-low reset, hold while rdy is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_r     <= '0;
            busy_cnt_r <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                val_r[i] <= '0;
                tag_r[i] <= '0;
            end
`ifdef REGFILE_CHECKPOINT_EN
            snap_busy_r <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                snap_tag_r[i] <= '0;
            end
`endif
        end else if (rdy) begin
            busy_r     <= busy_s;
            busy_cnt_r <= cnt_s;
            for (int i = 0; i < NUM_REGS; i++) begin
                val_r[i] <= val_s[i];
                tag_r[i] <= tag_s[i];
            end
`ifdef REGFILE_CHECKPOINT_EN
            snap_busy_r <= snap_busy_s;
            for (int i = 0; i < NUM_REGS; i++) begin
                snap_tag_r[i] <= snap_tag_s[i];
            end
`endif
        end
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Scoreboard bench for rename_regfile (default build, no checkpoint macro).
// The driver pushes predicted read results into a queue; a monitor pops and
// compares them against the live outputs each cycle.
module tb_rename_regfile;

    localparam int NR  = 32;
    localparam int RW  = 5;
    localparam int XL  = 32;
    localparam int TW  = 4;
    localparam int NRD = 2;
    localparam int NC  = 2;
    localparam int CW  = 6;

    logic              clk = 1'b0;
    logic              rst, rdy;
    logic [NRD*RW-1:0] rd_idx;
    logic [NRD*XL-1:0] rd_val;
    logic [NRD-1:0]    rd_busy;
    logic [NRD*TW-1:0] rd_tag;
    logic              issue;
    logic [RW-1:0]     issue_rd;
    logic [TW-1:0]     issue_tag;
    logic [NC-1:0]     cmt_vld;
    logic [NC*RW-1:0]  cmt_rd;
    logic [NC*XL-1:0]  cmt_val;
    logic [NC*TW-1:0]  cmt_tag;
    logic              rollback;
    logic [CW-1:0]     busy_cnt;

    always #5 clk = ~clk;

    rename_regfile dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rd_idx(rd_idx), .rd_val(rd_val), .rd_busy(rd_busy), .rd_tag(rd_tag),
        .issue(issue), .issue_rd(issue_rd), .issue_tag(issue_tag),
        .cmt_vld(cmt_vld), .cmt_rd(cmt_rd), .cmt_val(cmt_val), .cmt_tag(cmt_tag),
        .rollback(rollback), .busy_cnt(busy_cnt)
    );

    // Reference model: plain arrays updated by the architectural rules.
    logic [XL-1:0] m_val  [NR];
    bit            m_busy [NR];
    logic [TW-1:0] m_tag  [NR];

    typedef struct {
        logic [NRD*XL-1:0] val;
        logic [NRD-1:0]    busy;
        logic [NRD*TW-1:0] tag;
        logic [CW-1:0]     cnt;
        int                id;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    function automatic void chk(string nm, int id, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0h expected %0h", nm, id, act, exp);
        end
    endfunction

    function automatic exp_t predict();
        exp_t e;
        int   c;
        int   idx;
        c = 0;
        for (int p = 0; p < NRD; p++) begin
            idx = int'(rd_idx[p*RW +: RW]);
            e.val[p*XL +: XL] = '0;
            e.busy[p]         = 1'b0;
            e.tag[p*TW +: TW] = '0;
            if (idx != 0) begin
                e.val[p*XL +: XL] = m_val[idx];
                e.busy[p]         = m_busy[idx];
                e.tag[p*TW +: TW] = m_tag[idx];
                for (int k = 0; k < NC; k++) begin
                    if (cmt_vld[k] && int'(cmt_rd[k*RW +: RW]) == idx && m_busy[idx] &&
                        m_tag[idx] == cmt_tag[k*TW +: TW]) begin
                        e.val[p*XL +: XL] = cmt_val[k*XL +: XL];
                        e.busy[p]         = 1'b0;
                    end
                end
            end
        end
        for (int r = 0; r < NR; r++) c += int'(m_busy[r]);
        e.cnt = CW'(c);
        e.id  = cyc;
        return e;
    endfunction

    task automatic model_update();
        bit            wr   [NR];
        logic [TW-1:0] wtag [NR];
        int            r;
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin
                m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
        end else if (rdy) begin
            for (int i = 0; i < NR; i++) begin wr[i] = 1'b0; wtag[i] = '0; end
            for (int k = 0; k < NC; k++) begin
                r = int'(cmt_rd[k*RW +: RW]);
                if (cmt_vld[k] && r != 0) begin
                    m_val[r] = cmt_val[k*XL +: XL];
                    wr[r]    = 1'b1;
                    wtag[r]  = cmt_tag[k*TW +: TW];
                end
            end
            for (int i = 0; i < NR; i++)
                if (wr[i] && m_busy[i] && wtag[i] == m_tag[i]) m_busy[i] = 1'b0;
            if (issue && issue_rd != '0) begin
                m_busy[issue_rd] = 1'b1;
                m_tag[issue_rd]  = issue_tag;
            end
            if (rollback)
                for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        end
    endtask

    // One cycle: predict before the edge, update the model at the edge.
    task automatic step();
        @(negedge clk);
        #1;
        if (mon_en) q.push_back(predict());
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic clr();
        rdy = 1'b1; issue = 1'b0; issue_rd = '0; issue_tag = '0;
        cmt_vld = '0; cmt_rd = '0; cmt_val = '0; cmt_tag = '0;
        rollback = 1'b0; rd_idx = '0;
    endtask

    task automatic set_rd(input int a, input int b);
        rd_idx[0 +: RW]  = RW'(a);
        rd_idx[RW +: RW] = RW'(b);
    endtask

    task automatic do_issue(input int r, input int t);
        issue = 1'b1; issue_rd = RW'(r); issue_tag = TW'(t);
    endtask

    task automatic commit(input int k, input int r, input int t, input logic [XL-1:0] v);
        cmt_vld[k]          = 1'b1;
        cmt_rd[k*RW +: RW]  = RW'(r);
        cmt_tag[k*TW +: TW] = TW'(t);
        cmt_val[k*XL +: XL] = v;
    endtask

    // Monitor: compare the oldest prediction with the live outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int p = 0; p < NRD; p++) begin
                    chk("rd_val", e.id, 64'(rd_val[p*XL +: XL]), 64'(e.val[p*XL +: XL]));
                    chk("rd_busy", e.id, 64'(rd_busy[p]), 64'(e.busy[p]));
                    if (e.busy[p])
                        chk("rd_tag", e.id, 64'(rd_tag[p*TW +: TW]), 64'(e.tag[p*TW +: TW]));
                end
                chk("busy_cnt", e.id, 64'(busy_cnt), 64'(e.cnt));
            end
        end
    end

    initial begin
        int r;
        for (int i = 0; i < NR; i++) begin m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0; end
        clr();
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        mon_en = 1'b1;

        // Reset state.
        set_rd(5, 0); step();
        // Rename x5 -> tag 3.
        do_issue(5, 3); step();
        clr(); set_rd(5, 0); step();
        // Commit x5 with bypass, then stored value.
        commit(0, 5, 3, 32'hDEADBEEF); set_rd(5, 5); step();
        clr(); set_rd(5, 0); step();
        // Stale commit on a re-renamed register.
        do_issue(7, 2); step();
        clr(); do_issue(7, 6); step();
        clr(); commit(1, 7, 2, 32'h11); set_rd(7, 0); step();
        clr(); set_rd(7, 7); step();
        // Commit and issue to the same register in one cycle.
        do_issue(9, 8); step();
        clr(); commit(0, 9, 8, 32'h99); do_issue(9, 4); set_rd(9, 0); step();
        clr(); set_rd(9, 9); step();
        // Two commits to one register: younger wins the write.
        do_issue(10, 1); step();
        clr(); commit(0, 10, 1, 32'hA); commit(1, 10, 5, 32'hB); set_rd(10, 10); step();
        clr(); set_rd(10, 0); step();
        clr(); commit(0, 10, 5, 32'hC); commit(1, 10, 1, 32'hD); set_rd(10, 0); step();
        clr(); set_rd(10, 0); step();
        // Writes to x0 ignored.
        commit(0, 0, 0, 32'h55); do_issue(0, 7); set_rd(0, 0); step();
        clr(); set_rd(0, 0); step();
        // Rollback with rdy low holds, then with rdy high clears.
        do_issue(1, 1); step();
        clr(); do_issue(2, 2); step();
        clr(); do_issue(3, 3); step();
        clr(); rdy = 1'b0; rollback = 1'b1; do_issue(4, 4); set_rd(1, 2); step();
        clr(); set_rd(3, 4); step();
        clr(); rollback = 1'b1; do_issue(4, 4); set_rd(1, 3); step();
        clr(); set_rd(4, 2); step();
        // Reset mid-operation.
        do_issue(12, 9); step();
        clr(); rst = 1'b0; set_rd(12, 0); step();
        rst = 1'b1; clr(); set_rd(12, 5); step();

        // Randomized traffic concentrated on a few registers.
        for (int n = 0; n < 800; n++) begin
            clr();
            rst       = ($urandom_range(0, 99) != 0);
            rdy       = ($urandom_range(0, 9) != 0);
            issue     = 1'($urandom_range(0, 1));
            issue_rd  = RW'($urandom_range(0, 7));
            issue_tag = TW'($urandom);
            for (int k = 0; k < NC; k++) begin
                r = $urandom_range(0, 7);
                cmt_vld[k]          = ($urandom_range(0, 2) != 0);
                cmt_rd[k*RW +: RW]  = RW'(r);
                cmt_tag[k*TW +: TW] = ($urandom_range(0, 3) != 0) ? m_tag[r] : TW'($urandom);
                cmt_val[k*XL +: XL] = $urandom;
            end
            rollback = ($urandom_range(0, 19) == 0);
            for (int p = 0; p < NRD; p++)
                rd_idx[p*RW +: RW] = ($urandom_range(0, 1) != 0) ? cmt_rd[p*RW +: RW]
                                                                 : RW'($urandom_range(0, 8));
            step();
        end

        clr();
        step();
        repeat (3) @(negedge clk);
        chk("queue_drained", cyc, 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Parametrised architectural register file with per-register rename tags (busy bit + ROB position).
- Sits between the decoder/issue stage and the ROB.
- Serves NUM_RD source-operand lookups per cycle, with commit-to-read bypass.
- Accepts one rename per cycle and NUM_CMT in-order commits per cycle; clears all renames on rollback.

Parameters:
- NUM_REGS, 32: architectural registers; x0 hardwired to zero.
- REG_W, 5: register index width, $clog2(NUM_REGS).
- XLEN, 32: data width.
- ROB_W, 4: ROB position width.
- NUM_RD, 2: read port count.
- NUM_CMT, 2: commit port count; port index order = program order, higher index = younger.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- rdy  in  1  global enable; when low, all state is held.
- rd_idx  in  NUM_RD*REG_W  flattened source indices.
- rd_val  out  NUM_RD*XLEN  operand value.
- rd_busy  out  NUM_RD  1 = operand pending in ROB.
- rd_tag  out  NUM_RD*ROB_W  ROB position producing the operand; valid when busy.
- issue  in  1  rename request.
- issue_rd  in  REG_W  destination register.
- issue_tag  in  ROB_W  ROB position allocated.
- cmt_vld  in  NUM_CMT  commit valid per port.
- cmt_rd  in  NUM_CMT*REG_W  commit destinations.
- cmt_val  in  NUM_CMT*XLEN  commit values.
- cmt_tag  in  NUM_CMT*ROB_W  ROB position being committed.
- rollback  in  1  mispredict flush.
- busy_cnt  out  $clog2(NUM_REGS+1)  registered count of busy registers.

Behaviour:
- Reset (rst==0 at posedge): all values 0, all busy 0, all tags 0, busy_cnt 0.
  - Reset overrides rdy.
  - Reset mid-operation discards pending renames.
- Reads are combinational (0-cycle), per port p, checked in this order:
  - idx==0: val 0, busy 0, tag 0.
  - Else, if some cmt_vld[k] has cmt_rd[k]==idx, cmt_rd[k]!=0, busy[idx]==1 and tag[idx]==cmt_tag[k]: val=cmt_val[k], busy 0 (bypass). If several ports match, the highest k wins.
  - Else: stored val, busy and tag.
- A same-cycle issue does NOT affect reads. The decoder reads sources before its own destination is renamed.
- Update at posedge when rst==1 and rdy==1, in this order:
  - Commits: for each k with cmt_vld[k] and cmt_rd[k]!=0, write cmt_val[k] to val[cmt_rd[k]].
    - If tag matches and the register is busy, clear busy.
    - Two commits to the same rd in one cycle: the higher k value wins; busy clears only if the winner's tag matches.
  - Issue: if issue and issue_rd!=0, set busy=1 and tag=issue_tag. This overrides a same-cycle commit clear on the same register.
  - Rollback: clear all busy bits. Overrides issue; values from same-cycle commits are still written.
- Writes to x0 are ignored on all paths.
- busy_cnt is recomputed from next-state busy bits and registered. Range is 0..NUM_REGS-1 (x0 never busy).
- rdy==0: no state change; reads remain live.

Optional Feature:
- Macro REGFILE_CHECKPOINT_EN adds a one-deep checkpoint of the busy/tag table.
- Extra ports when enabled:
  - ckpt_save in 1: snapshot taken at posedge after the same-cycle issue is applied.
  - ckpt_restore in 1: replaces the rollback clear-all.
- On ckpt_restore, busy/tag is restored from the snapshot, except that entries whose tag matches any same-cycle commit are cleared.
- Save and restore in the same cycle: restore wins; the snapshot is unchanged.
- Without the macro: no extra ports; rollback clears all busy bits.

Decomposition:
- Shared package/define file: REG_W, XLEN, ROB_W defaults; a busy+tag entry struct/width macro; NUM_REGS constant.
- Sub-module rf_cmt_match: per-read-port priority match over the NUM_CMT commit ports, returning hit, value and index. Reused by the bypass logic and the busy-clear logic.

Test Plan:
- Reset, then read x5 and x0 -> val 0, busy 0, busy_cnt 0.
- Issue rd=5, tag=3; next cycle read x5 -> busy 1, tag 3, busy_cnt 1.
- Commit rd=5, tag=3, val=0xDEADBEEF; read x5 in the same cycle -> bypass val 0xDEADBEEF, busy 0; next cycle stored val 0xDEADBEEF, busy_cnt 0.
- Issue x7 with tag 2, then tag 6; commit tag 2 val 0x11 -> x7 val 0x11, still busy with tag 6.
- Same cycle: commit x9 (tag matches) and issue x9 tag 4 -> x9 busy tag 4, val updated.
- Busy x1/x2/x3; assert rollback with a simultaneous issue x4 -> all busy 0, busy_cnt 0; same test with rdy=0 -> state unchanged.
